// File: rtl/distribute.sv
// rtl/distribute.sv - registered 1-to-4 write-back distributor with per-slot valid/ack drain
//
// Steers one WIDTH-bit producer word into one of four single-entry holding
// registers (A..D), selected by select_code. Each slot drains to its own
// consumer through out_valid[i]/out_ack[i].
//
// Ports:
//   CLK          rising-edge clock
//   RST          asynchronous active-low reset
//   DataIn       producer write data
//   select_code  destination slot, 0=A 1=B 2=C 3=D
//   in_valid     producer offers DataIn/select_code this cycle
//   in_ready     selected slot can accept this cycle (combinational)
//   DataOutA..D  holding-register contents (registered)
//   out_valid    bit i set = slot i holds unconsumed data
//   out_ack      bit i = consumer i takes slot i this cycle
//   stall_cnt    saturating count of cycles with in_valid=1 and in_ready=0

module distribute #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [1:0]       select_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] DataOutA,
    output logic [WIDTH-1:0] DataOutB,
    output logic [WIDTH-1:0] DataOutC,
    output logic [WIDTH-1:0] DataOutD,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state_q [4];
    slot_state_t      state_d [4];
    logic [3:0]       load;
    logic [WIDTH-1:0] data_q  [4];
    logic             accept;
    logic             stall;
    logic [CNT_W-1:0] stall_q;

    // A full slot that is being acked this cycle frees up in time to take
    // the new word, so the producer is not stalled by a draining slot.
    always_comb begin
        in_ready = (state_q[select_code] == SLOT_EMPTY) | out_ack[select_code];
        accept   = in_valid & in_ready;
        stall    = in_valid & ~in_ready;
    end

    // Next state per slot. A load on the same slot as an ack wins, so the
    // slot stays full with the new word while the old word is consumed.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            load[i]    = accept && (select_code == 2'(i));
            if (load[i]) begin
                state_d[i] = SLOT_FULL;
            end else if (state_q[i] == SLOT_FULL && out_ack[i]) begin
                state_d[i] = SLOT_EMPTY;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= SLOT_EMPTY;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                // Consumed data is left in place; only a load changes it.
                if (load[i]) begin
                    data_q[i] <= DataIn;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_q <= '0;
        end else if (stall && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = (state_q[i] == SLOT_FULL);
        end
        DataOutA  = data_q[0];
        DataOutB  = data_q[1];
        DataOutC  = data_q[2];
        DataOutD  = data_q[3];
        stall_cnt = stall_q;
    end

endmodule

// File: tb/tb_distribute.sv
// tb/tb_distribute.sv - scoreboard bench for the 1-to-4 write-back distributor

module tb_distribute;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             CLK;
    logic             RST;
    logic [WIDTH-1:0] DataIn;
    logic [1:0]       select_code;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] DataOutA, DataOutB, DataOutC, DataOutD;
    logic [3:0]       out_valid;
    logic [3:0]       out_ack;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Expected words per slot, pushed at accept, popped when consumed.
    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];
    logic [WIDTH-1:0] exp_q2[$];
    logic [WIDTH-1:0] exp_q3[$];

    // Reference state of the slots as seen from the bench.
    logic [3:0]       m_valid;
    logic [WIDTH-1:0] m_data [4];
    int               m_stall;

    distribute #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK),
        .RST(RST),
        .DataIn(DataIn),
        .select_code(select_code),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .DataOutA(DataOutA),
        .DataOutB(DataOutB),
        .DataOutC(DataOutC),
        .DataOutD(DataOutD),
        .out_valid(out_valid),
        .out_ack(out_ack),
        .stall_cnt(stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] dout(input int i);
        case (i)
            0:       return DataOutA;
            1:       return DataOutB;
            2:       return DataOutC;
            default: return DataOutD;
        endcase
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int slot, input logic [WIDTH-1:0] d);
        case (slot)
            0:       exp_q0.push_back(d);
            1:       exp_q1.push_back(d);
            2:       exp_q2.push_back(d);
            default: exp_q3.push_back(d);
        endcase
    endtask

    // Monitor: every consumed word must match the oldest expected word of that slot.
    always @(negedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ack[i]) begin
                    logic [WIDTH-1:0] e;
                    int               sz;
                    case (i)
                        0:       sz = exp_q0.size();
                        1:       sz = exp_q1.size();
                        2:       sz = exp_q2.size();
                        default: sz = exp_q3.size();
                    endcase
                    checks++;
                    if (sz == 0) begin
                        errors++;
                        $display("FAIL consume_unexpected slot %0d: got 0x%0h expected no data", i, dout(i));
                    end else begin
                        case (i)
                            0:       e = exp_q0.pop_front();
                            1:       e = exp_q1.pop_front();
                            2:       e = exp_q2.pop_front();
                            default: e = exp_q3.pop_front();
                        endcase
                        checks--;
                        check($sformatf("consume_data slot %0d", i), dout(i), e);
                    end
                end
            end
        end
    end

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic cyc(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d, input logic [3:0] ack);
        logic exp_ready;
        in_valid    = v;
        select_code = sel;
        DataIn      = d;
        out_ack     = ack;
        @(negedge CLK);
        exp_ready = !m_valid[sel] || ack[sel];
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) m_valid[i] = 1'b0;
        end
        if (v && exp_ready) begin
            push_exp(int'(sel), d);
            m_valid[sel] = 1'b1;
            m_data[sel]  = d;
        end
        if (v && !exp_ready && m_stall != 255) m_stall++;
        @(posedge CLK);
        #1;
        check("out_valid", {28'd0, out_valid}, {28'd0, m_valid});
        check("stall_cnt", {24'd0, stall_cnt}, m_stall);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("data_out slot %0d", i), dout(i), m_data[i]);
        end
    endtask

    task automatic model_reset();
        m_valid = 4'b0000;
        m_stall = 0;
        for (int i = 0; i < 4; i++) m_data[i] = '0;
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        exp_q3.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst out_valid", {28'd0, out_valid}, 32'd0);
        check("rst stall_cnt", {24'd0, stall_cnt}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst data_out slot %0d", i), dout(i), 32'd0);
        end
    endtask

    initial begin
        RST         = 1'b0;
        DataIn      = '0;
        select_code = 2'd0;
        in_valid    = 1'b0;
        out_ack     = 4'b0000;
        model_reset();
        #2;
        check_reset_outputs();
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Basic scatter, one write per slot, no acks
        cyc(1'b1, 2'd0, 32'h11111111, 4'b0000);
        cyc(1'b1, 2'd1, 32'h22222222, 4'b0000);
        cyc(1'b1, 2'd2, 32'h33333333, 4'b0000);
        cyc(1'b1, 2'd3, 32'h44444444, 4'b0000);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);
        check("scatter all full", {28'd0, out_valid}, 32'h0000000F);
        cyc(1'b0, 2'd0, 32'h0, 4'b1111);

        // Backpressure on slot B, released by an ack on the fourth cycle
        cyc(1'b1, 2'd1, 32'hAAAA0000, 4'b0000);
        repeat (3) cyc(1'b1, 2'd1, 32'hBBBB0000, 4'b0000);
        check("backpressure stall_cnt", {24'd0, stall_cnt}, 32'd3);
        check("backpressure held data", DataOutB, 32'hAAAA0000);
        cyc(1'b1, 2'd1, 32'hBBBB0000, 4'b0010);
        check("backpressure new data", DataOutB, 32'hBBBB0000);

        // Same-cycle consume and refill on slot D
        cyc(1'b1, 2'd3, 32'h12345678, 4'b0000);
        cyc(1'b1, 2'd3, 32'hDEADBEEF, 4'b1000);
        check("refill data D", DataOutD, 32'hDEADBEEF);

        // Stray acks with only C full while A is written
        cyc(1'b0, 2'd0, 32'h0, 4'b1010);
        cyc(1'b1, 2'd2, 32'hCCCC0001, 4'b0000);
        cyc(1'b1, 2'd0, 32'hA0A0A0A0, 4'b1111);
        check("stray ack valid", {28'd0, out_valid}, 32'h00000001);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);

        // Asynchronous reset with A and C full
        cyc(1'b1, 2'd2, 32'hC2C2C2C2, 4'b0000);
        in_valid = 1'b0;
        out_ack  = 4'b0000;
        #3;
        RST = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Saturating stall counter on a blocked slot B
        cyc(1'b1, 2'd1, 32'h5A5A5A5A, 4'b0000);
        repeat (300) cyc(1'b1, 2'd1, 32'h6B6B6B6B, 4'b0000);
        check("saturated stall_cnt", {24'd0, stall_cnt}, 32'd255);
        cyc(1'b0, 2'd0, 32'h0, 4'b0010);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);

        check("leftover expected words", exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/distribute.md
Name: distribute

Overview:
- Registered 1-to-4 write-back distributor for the multicycle CPU datapath.
- One 32-bit producer (ALU result, memory data, PC+4, immediate) is steered by a 2-bit code into one of four single-entry holding registers.
- Each holding register drains independently to its consumer through a valid/ack handshake.
- It is the write-side counterpart of the 4-to-1 source selector: that block gathers four sources into one; this block scatters one source into four sinks, with buffering and flow control.

Parameters:
- WIDTH, 32, data width of DataIn and each DataOut.
- CNT_W, 8, width of the saturating stall counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- DataIn  input  WIDTH  write data from the producer.
- select_code  input  2  destination: 0=A, 1=B, 2=C, 3=D.
- in_valid  input  1  producer offers DataIn/select_code this cycle.
- in_ready  output  1  destination slot can accept this cycle (combinational).
- DataOutA, DataOutB, DataOutC, DataOutD  output  WIDTH  holding-register contents.
- out_valid  output  4  bit i set = slot i holds unconsumed data (bit0=A ... bit3=D).
- out_ack  input  4  bit i = consumer i takes slot i this cycle; ignored when out_valid[i]=0.
- stall_cnt  output  CNT_W  cycles in which in_valid=1 and in_ready=0, saturating.

Behaviour:
- Reset (RST=0, asynchronous, no clock needed):
  - DataOutA..D = 0, out_valid = 0, stall_cnt = 0.
  - in_ready reflects the empty slots, so it is 1.
  - Any transfer in flight is discarded.
  - Release is synchronous in effect: the first accept is possible on the first rising edge with RST=1.
- Per slot i, two states: EMPTY (out_valid[i]=0) and FULL (out_valid[i]=1).
- in_ready = !out_valid[select_code] | out_ack[select_code].
  - Pass-through: a slot that is FULL and acked in the same cycle can accept.
- Accept (in_valid & in_ready at the rising edge):
  - DataOut[select_code] <= DataIn; out_valid[select_code] <= 1.
  - Latency 1 cycle: data is visible on DataOutX and out_valid[X] the cycle after accept.
- Consume: out_ack[i] & out_valid[i] at the edge -> out_valid[i] <= 0; DataOut[i] holds its last value (not cleared).
- Simultaneous consume and accept on the same slot: the accept wins. out_valid stays 1, the new data is loaded, and the old data is consumed.
- Acks to the other three slots are processed in the same cycle as an accept, independently.
- in_valid=0: in_ready is still driven from the current select_code, but no state changes.
- Blocked: a write to a FULL, un-acked slot is not accepted.
  - No overwrite and no loss; the producer must hold DataIn and select_code stable until accepted.
  - Behaviour when the producer changes them while blocked is undefined.
- Non-blocking: a stall on one slot never blocks the other slots' acks.
- stall_cnt:
  - Increments by 1 on each edge where in_valid=1 and in_ready=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- out_ack bits for EMPTY slots have no effect on any state.
- No combinational path from DataIn to DataOut; all outputs except in_ready are registered.

Test Plan:
- Reset values: assert RST=0 mid-run with slots A and C FULL -> out_valid=4'b0000, all DataOut=0, stall_cnt=0, in_ready=1, all immediately without a clock edge.
- Basic scatter: write 0x11111111->0, 0x22222222->1, 0x33333333->2, 0x44444444->3 on four consecutive cycles with no acks -> each out_valid bit rises 1 cycle after its accept; DataOutA..D hold those values; out_valid=4'b1111.
- Backpressure: slot B FULL with 0xAAAA0000; offer 0xBBBB0000 to code 1 for 3 cycles without ack -> in_ready=0, DataOutB stays 0xAAAA0000, stall_cnt=3; ack B on cycle 4 -> accepted in that cycle, DataOutB=0xBBBB0000 and out_valid[1]=1 next cycle.
- Same-cycle consume and refill: slot D FULL, out_ack=4'b1000 together with a write of 0xDEADBEEF to code 3 -> in_ready=1; next cycle out_valid[3]=1, DataOutD=0xDEADBEEF.
- Stray ack plus independent slots: out_ack=4'b1111 with only slot C FULL, while a write goes to slot A -> C cleared, A set, B and D unchanged; acks to empty slots cause no change.
- Saturation (CNT_W=8): hold a blocked write for 300 cycles -> stall_cnt reaches 255 and stays at 255.
